// File: rtl/prog_sequencer.sv
// Run controller for the PC block: program select, PC init/advance gating, end detection,
// cycle-limit watchdog and Start/Done handshake. Optional SEQ_SINGLE_STEP_EN adds Step/Step_mode.
module prog_sequencer #(
    parameter int W          = 16,
    parameter int CW         = 16,
    parameter int P0_START   = 0,
    parameter int P0_END     = 140,
    parameter int P1_START   = 150,
    parameter int P1_END     = 300,
    parameter int P2_START   = 310,
    parameter int P2_END     = 500,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          CLK,
    input  logic          Init_n,
    input  logic          Start,
    input  logic [1:0]    Prog_sel,
    input  logic [W-1:0]  Pc,
    input  logic          Halt_in,
    input  logic          Stall,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic          Step,
    input  logic          Step_mode,
`endif
    output logic          Pc_init,
    output logic [W-1:0]  Start_addr,
    output logic          Pc_en,
    output logic          Busy,
    output logic          Done,
    output logic          Timeout,
    output logic [CW-1:0] Cycle_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   end_addr;
    logic [W-1:0]   sel_start, sel_end;
    logic           sel_ok;
    logic           run_q;
    logic           adv;
    logic           end_hit;
    logic           wd_hit;

    // adv marks RUN cycles that count toward Cycle_cnt and the watchdog
`ifdef SEQ_SINGLE_STEP_EN
    assign adv   = ~Step_mode | (Step & ~Stall);
    assign Pc_en = run_q & ~Stall & (~Step_mode | Step);
`else
    assign adv   = 1'b1;
    assign Pc_en = run_q & ~Stall;
`endif

    assign sel_ok  = Start & (Prog_sel != 2'd3);
    assign end_hit = Halt_in | (Pc == end_addr);
    assign wd_hit  = adv & (Cycle_cnt == CW'(MAX_CYCLES - 1));

    always_comb begin
        sel_start = W'(P0_START);
        sel_end   = W'(P0_END);
        case (Prog_sel)
            2'd1: begin
                sel_start = W'(P1_START);
                sel_end   = W'(P1_END);
            end
            2'd2: begin
                sel_start = W'(P2_START);
                sel_end   = W'(P2_END);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sel_ok) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   if (end_hit || wd_hit) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control flags are decoded from the next state so they come straight off flops
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state      <= S_IDLE;
            Pc_init    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            run_q      <= 1'b0;
            Timeout    <= 1'b0;
            Start_addr <= '0;
            end_addr   <= '0;
            Cycle_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            Pc_init <= (state_nxt == S_LOAD);
            Busy    <= (state_nxt != S_IDLE);
            Done    <= (state_nxt == S_DONE);
            run_q   <= (state_nxt == S_RUN);
            if (state == S_IDLE && sel_ok) begin
                Start_addr <= sel_start;
                end_addr   <= sel_end;
            end
            // A watchdog exit leaves the count at MAX_CYCLES-1; a normal end counts its last cycle
            if (state == S_LOAD) begin
                Cycle_cnt <= '0;
                Timeout   <= 1'b0;
            end else if (state == S_RUN) begin
                if (!end_hit && wd_hit)
                    Timeout <= 1'b1;
                else if (adv)
                    Cycle_cnt <= Cycle_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a small PC block stand-in (watchdog limit 160).
module tb_prog_sequencer;

    localparam int W  = 16;
    localparam int CW = 16;
    localparam int MAXC = 160;

    logic          clk = 1'b0;
    logic          Init_n = 1'b0;
    logic          Start = 1'b0;
    logic [1:0]    Prog_sel = 2'd0;
    logic [W-1:0]  Pc = '0;
    logic          Halt_in = 1'b0;
    logic          Stall = 1'b0;
    logic          Pc_init;
    logic [W-1:0]  Start_addr;
    logic          Pc_en;
    logic          Busy;
    logic          Done;
    logic          Timeout;
    logic [CW-1:0] Cycle_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    bit use_model = 1'b1;

    always #5 clk = ~clk;

    prog_sequencer #(.W(W), .CW(CW), .MAX_CYCLES(MAXC)) dut (
        .CLK(clk), .Init_n(Init_n), .Start(Start), .Prog_sel(Prog_sel), .Pc(Pc),
        .Halt_in(Halt_in), .Stall(Stall), .Pc_init(Pc_init), .Start_addr(Start_addr),
        .Pc_en(Pc_en), .Busy(Busy), .Done(Done), .Timeout(Timeout), .Cycle_cnt(Cycle_cnt)
    );

    // One clock; the PC stand-in loads on Pc_init and increments on Pc_en
    task automatic tick();
        logic pi, pe;
        logic [W-1:0] sa;
        #1;
        pi = Pc_init; pe = Pc_en; sa = Start_addr;
        @(posedge clk); #1;
        if (use_model) Pc = pi ? sa : (pe ? Pc + 1'b1 : Pc);
    endtask

    task automatic start_prog(input logic [1:0] sel);
        Start = 1'b1; Prog_sel = sel;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        #22;
        n_chk++; if (Busy !== 1'b0 || Pc_init !== 1'b0 || Pc_en !== 1'b0 || Done !== 1'b0) $display("FAIL reset_ctrl: busy=%b init=%b en=%b done=%b want 0000", Busy, Pc_init, Pc_en, Done); else n_pass++;
        n_chk++; if (Start_addr !== 16'd0 || Cycle_cnt !== 16'd0 || Timeout !== 1'b0) $display("FAIL reset_data: addr=%0d cnt=%0d to=%b want 0 0 0", Start_addr, Cycle_cnt, Timeout); else n_pass++;
        Init_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_start_latency();
        start_prog(2'd0);
        n_chk++; if (Pc_init !== 1'b1 || Busy !== 1'b1 || Pc_en !== 1'b0) $display("FAIL load_cycle: init=%b busy=%b en=%b want 1 1 0", Pc_init, Busy, Pc_en); else n_pass++;
        n_chk++; if (Start_addr !== 16'd0) $display("FAIL load_addr: got %0d want 0", Start_addr); else n_pass++;
        tick();
        n_chk++; if (Pc_en !== 1'b1 || Pc_init !== 1'b0 || Pc !== 16'd0) $display("FAIL first_run: en=%b init=%b pc=%0d want 1 0 0", Pc_en, Pc_init, Pc); else n_pass++;
    endtask

    task automatic test_end_marker();
        for (int i = 0; i < 140; i++) tick();
        n_chk++; if (Pc !== 16'd140 || Pc_en !== 1'b1 || Cycle_cnt !== 16'd140) $display("FAIL pre_end: pc=%0d en=%b cnt=%0d want 140 1 140", Pc, Pc_en, Cycle_cnt); else n_pass++;
        tick();
        n_chk++; if (Pc_en !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) $display("FAIL drain: en=%b busy=%b done=%b want 0 1 0", Pc_en, Busy, Done); else n_pass++;
        tick();
        n_chk++; if (Done !== 1'b1 || Busy !== 1'b1 || Timeout !== 1'b0 || Cycle_cnt !== 16'd141) $display("FAIL end_done: done=%b busy=%b to=%b cnt=%0d want 1 1 0 141", Done, Busy, Timeout, Cycle_cnt); else n_pass++;
        tick();
        n_chk++; if (Done !== 1'b0 || Busy !== 1'b0 || Cycle_cnt !== 16'd141) $display("FAIL end_idle: done=%b busy=%b cnt=%0d want 0 0 141", Done, Busy, Cycle_cnt); else n_pass++;
    endtask

    task automatic test_watchdog();
        use_model = 1'b0; Pc = '0;
        start_prog(2'd1);
        tick();
        for (int i = 0; i < MAXC - 1; i++) tick();
        n_chk++; if (Pc_en !== 1'b1 || Timeout !== 1'b0 || Cycle_cnt !== 16'(MAXC - 1)) $display("FAIL wd_pre: en=%b to=%b cnt=%0d want 1 0 %0d", Pc_en, Timeout, Cycle_cnt, MAXC - 1); else n_pass++;
        tick();
        n_chk++; if (Pc_en !== 1'b0 || Timeout !== 1'b1 || Cycle_cnt !== 16'(MAXC - 1)) $display("FAIL wd_fire: en=%b to=%b cnt=%0d want 0 1 %0d", Pc_en, Timeout, Cycle_cnt, MAXC - 1); else n_pass++;
        tick();
        n_chk++; if (Done !== 1'b1) $display("FAIL wd_done: got %b want 1", Done); else n_pass++;
        tick();
        n_chk++; if (Busy !== 1'b0 || Timeout !== 1'b1 || Start_addr !== 16'd150) $display("FAIL wd_hold: busy=%b to=%b addr=%0d want 0 1 150", Busy, Timeout, Start_addr); else n_pass++;
    endtask

    task automatic test_end_vs_watchdog();
        start_prog(2'd2);
        n_chk++; if (Timeout !== 1'b1) $display("FAIL to_sticky_in_load: got %b want 1", Timeout); else n_pass++;
        tick();
        n_chk++; if (Timeout !== 1'b0 || Cycle_cnt !== 16'd0) $display("FAIL load_clear: to=%b cnt=%0d want 0 0", Timeout, Cycle_cnt); else n_pass++;
        for (int i = 0; i < MAXC - 1; i++) tick();
        Halt_in = 1'b1;
        tick();
        Halt_in = 1'b0;
        n_chk++; if (Pc_en !== 1'b0 || Timeout !== 1'b0 || Cycle_cnt !== 16'(MAXC)) $display("FAIL end_wins: en=%b to=%b cnt=%0d want 0 0 %0d", Pc_en, Timeout, Cycle_cnt, MAXC); else n_pass++;
        tick(); tick();
        use_model = 1'b1;
    endtask

    task automatic test_ignored_start();
        Start = 1'b1; Prog_sel = 2'd3;
        tick(); tick();
        Start = 1'b0;
        n_chk++; if (Busy !== 1'b0 || Pc_init !== 1'b0 || Start_addr !== 16'd310) $display("FAIL bad_sel: busy=%b init=%b addr=%0d want 0 0 310", Busy, Pc_init, Start_addr); else n_pass++;
        start_prog(2'd0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        Start = 1'b1; Prog_sel = 2'd1;
        tick();
        Start = 1'b0;
        n_chk++; if (Pc_init !== 1'b0 || Pc_en !== 1'b1 || Busy !== 1'b1 || Start_addr !== 16'd0) $display("FAIL run_start: init=%b en=%b busy=%b addr=%0d want 0 1 1 0", Pc_init, Pc_en, Busy, Start_addr); else n_pass++;
    endtask

    task automatic test_stall();
        n_chk++; if (Pc !== 16'd6 || Cycle_cnt !== 16'd6) $display("FAIL stall_pre: pc=%0d cnt=%0d want 6 6", Pc, Cycle_cnt); else n_pass++;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (Pc_en !== 1'b0) $display("FAIL stall_en%0d: got %b want 0", i, Pc_en); else n_pass++;
            tick();
        end
        n_chk++; if (Pc !== 16'd6 || Cycle_cnt !== 16'd9 || Busy !== 1'b1) $display("FAIL stall_post: pc=%0d cnt=%0d busy=%b want 6 9 1", Pc, Cycle_cnt, Busy); else n_pass++;
        Halt_in = 1'b1;
        tick();
        Halt_in = 1'b0; Stall = 1'b0;
        n_chk++; if (Pc_en !== 1'b0 || Done !== 1'b0 || Cycle_cnt !== 16'd10 || Pc !== 16'd6) $display("FAIL stall_halt: en=%b done=%b cnt=%0d pc=%0d want 0 0 10 6", Pc_en, Done, Cycle_cnt, Pc); else n_pass++;
        tick();
        n_chk++; if (Done !== 1'b1 || Timeout !== 1'b0) $display("FAIL stall_done: done=%b to=%b want 1 0", Done, Timeout); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        start_prog(2'd1);
        tick(); tick(); tick();
        Init_n = 1'b0;
        #1;
        n_chk++; if (Pc_en !== 1'b0 || Busy !== 1'b0 || Pc_init !== 1'b0 || Timeout !== 1'b0) $display("FAIL mid_rst_ctrl: en=%b busy=%b init=%b to=%b want 0000", Pc_en, Busy, Pc_init, Timeout); else n_pass++;
        n_chk++; if (Start_addr !== 16'd0 || Cycle_cnt !== 16'd0) $display("FAIL mid_rst_data: addr=%0d cnt=%0d want 0 0", Start_addr, Cycle_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Done !== 1'b0) done_seen++;
        end
        Init_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Done !== 1'b0) done_seen++;
        end
        n_chk++; if (done_seen != 0 || Busy !== 1'b0) $display("FAIL mid_rst_nodone: done_cycles=%0d busy=%b want 0 0", done_seen, Busy); else n_pass++;
        start_prog(2'd2);
        n_chk++; if (Pc_init !== 1'b1 || Start_addr !== 16'd310) $display("FAIL restart_load: init=%b addr=%0d want 1 310", Pc_init, Start_addr); else n_pass++;
        tick();
        n_chk++; if (Pc_en !== 1'b1 || Pc !== 16'd310 || Cycle_cnt !== 16'd0) $display("FAIL restart_run: en=%b pc=%0d cnt=%0d want 1 310 0", Pc_en, Pc, Cycle_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_end_marker();
        test_watchdog();
        test_end_vs_watchdog();
        test_ignored_start();
        test_stall();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: sim still running at %0t, want finished", $time);
        $fatal(1, "time limit");
    end

endmodule
